// File: rtl/spi_frame_rx.sv
// SPI write-frame receiver: synchronizes pad-level SPI signals into the clk domain,
// shifts 16-bit frames and emits a register-write strobe or a frame-error strobe.
module spi_frame_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       cs_n,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_err,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int unsigned LAST = SYNC_STAGES - 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_sync;
   logic                   sclk_hist, cs_hist;
   logic                   fresh, armed;
   logic                   sclk_rise_ev, cs_rise_ev, cs_fall_ev, copi_ev;

   state_t      state, state_next;
   logic [4:0]  bit_cnt, cnt_next;
   logic [15:0] shreg, shreg_next;
   logic        accept, reject;

   // armed blocks the fake cs_n fall seen when the chain leaves reset (high)
   // while the pad is already low; a real high sample must come first.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync    <= '0;
         copi_sync    <= '0;
         cs_sync      <= '1;
         sclk_hist    <= 1'b0;
         cs_hist      <= 1'b1;
         fresh        <= 1'b0;
         armed        <= 1'b0;
         sclk_rise_ev <= 1'b0;
         cs_rise_ev   <= 1'b0;
         cs_fall_ev   <= 1'b0;
         copi_ev      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous value of its neighbour.
         sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync    <= {copi_sync[SYNC_STAGES-2:0], copi};
         cs_sync      <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sclk_hist    <= sclk_sync[LAST];
         cs_hist      <= cs_sync[LAST];
         fresh        <= 1'b1;
         armed        <= armed | (fresh & cs_sync[0]);
         sclk_rise_ev <= sclk_sync[LAST] & ~sclk_hist;
         cs_rise_ev   <= cs_sync[LAST] & ~cs_hist;
         cs_fall_ev   <= armed & ~cs_sync[LAST] & cs_hist;
         copi_ev      <= copi_sync[LAST];
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      state_next = state;
      cnt_next   = bit_cnt;
      shreg_next = shreg;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall_ev) begin
               state_next = SHIFT;
               cnt_next   = '0;
               shreg_next = '0;
            end
         end
         SHIFT: begin
            if (cs_rise_ev) begin
               state_next = IDLE;
               if (bit_cnt == 5'd16 && shreg[15] && shreg[14:8] <= MAX_ADDR)
                  accept = 1'b1;
               else if (bit_cnt != 5'd16 || shreg[15])
                  reject = 1'b1;
            end else if (sclk_rise_ev) begin
               shreg_next = {shreg[14:0], copi_ev};
               if (bit_cnt != 5'd31)
                  cnt_next = bit_cnt + 5'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_next;
         bit_cnt   <= cnt_next;
         shreg     <= shreg_next;
         wr_valid  <= accept;
         frame_err <= reject;
         if (accept) begin
            wr_addr <= shreg[14:8];
            wr_data <= shreg[7:0];
         end
         if (reject && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: bit-bangs SPI frames and checks strobes,
// fields, latency, error counting and reset behaviour against hand-computed values.
module tb_spi_frame_rx;

   localparam int unsigned SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       cs_n = 1'b1;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_err;
   logic [7:0] err_count;
   logic       busy;

   spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .cs_n(cs_n),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_err(frame_err), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled on the falling edge
   int         n_wr = 0, n_err = 0, n_both = 0, n_busy = 0, last_wr_cyc = 0;
   logic [6:0] log_addr[$];
   logic [7:0] log_data[$];
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_valid) begin
            n_wr++;
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            last_wr_cyc = cyc;
         end
         if (frame_err) n_err++;
         if (wr_valid && frame_err) n_both++;
         if (busy) n_busy++;
      end
   end

   int n_tests = 0, n_fail = 0;
   int rise_cyc = 0;
   logic busy_mid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      wait_clks(2);
      rst = 1'b0;
      wait_clks(6);
   endtask

   task automatic cs_low();
      @(posedge clk); #1 cs_n = 1'b0;
      wait_clks(6);
      busy_mid = busy;
   endtask

   task automatic cs_high(input int gap);
      @(posedge clk); #1 cs_n = 1'b1;
      rise_cyc = cyc;
      wait_clks(gap);
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(posedge clk); #1;
         copi = bits[i];
         sclk = 1'b0;
         wait_clks(4);
         sclk = 1'b1;
         wait_clks(3);
      end
      @(posedge clk); #1 sclk = 1'b0;
      wait_clks(4);
   endtask

   task automatic frame(input logic [31:0] bits, input int n);
      cs_low();
      send_bits(bits, n);
      cs_high(12);
   endtask

   int wr0, er0, bz0;

   initial begin
      // reset state
      wait_clks(3);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst = 1'b0;
      wait_clks(6);

      // single write frame with latency check
      wr0 = n_wr; er0 = n_err;
      frame(32'h8155, 16);
      check("w1_busy_mid", busy_mid, 1);
      check("w1_count", n_wr - wr0, 1);
      check("w1_addr", log_addr[wr0], 7'h01);
      check("w1_data", log_data[wr0], 8'h55);
      check("w1_latency", last_wr_cyc - rise_cyc, SYNC_STAGES + 2);
      check("w1_no_err", n_err - er0, 0);
      check("w1_busy_after", busy, 0);
      check("w1_addr_hold", wr_addr, 7'h01);
      check("w1_data_hold", wr_data, 8'h55);

      // short and long frames
      wr0 = n_wr; er0 = n_err;
      frame(32'h4155, 15);
      frame(32'h10155, 17);
      check("len_err_pulses", n_err - er0, 2);
      check("len_err_count", err_count, 2);
      check("len_no_wr", n_wr - wr0, 0);

      // address range and read frames
      do_reset();
      wr0 = n_wr; er0 = n_err;
      frame(32'h8AFF, 16);
      check("addr10_err", n_err - er0, 1);
      check("addr10_err_count", err_count, 1);
      check("addr10_no_wr", n_wr - wr0, 0);
      frame(32'h0312, 16);
      check("read_no_err", n_err - er0, 1);
      check("read_no_wr", n_wr - wr0, 0);
      frame(32'h84A5, 16);
      check("addr4_wr", n_wr - wr0, 1);
      check("addr4_addr", log_addr[wr0], 7'h04);
      check("addr4_data", log_data[wr0], 8'hA5);
      frame(32'h8501, 16);
      check("addr5_err_count", err_count, 2);
      check("addr5_no_wr", n_wr - wr0, 1);

      // reset in the middle of a frame
      wr0 = n_wr; er0 = n_err;
      cs_low();
      send_bits(32'h81, 8);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      bz0 = n_busy;
      send_bits(32'h55, 8);
      cs_high(12);
      check("midrst_no_wr", n_wr - wr0, 0);
      check("midrst_no_err", n_err - er0, 0);
      check("midrst_busy", n_busy - bz0, 0);

      // back-to-back writes
      wr0 = n_wr;
      cs_low();
      send_bits(32'h8011, 16);
      cs_high(4);
      cs_low();
      send_bits(32'h8422, 16);
      cs_high(12);
      check("b2b_count", n_wr - wr0, 2);
      check("b2b_addr0", log_addr[wr0], 7'h00);
      check("b2b_data0", log_data[wr0], 8'h11);
      check("b2b_addr1", log_addr[wr0 + 1], 7'h04);
      check("b2b_data1", log_data[wr0 + 1], 8'h22);

      // error counter saturation
      do_reset();
      er0 = n_err;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1 cs_n = 1'b0;
         wait_clks(6);
         cs_n = 1'b1;
         wait_clks(6);
      end
      wait_clks(6);
      check("sat_err_pulses", n_err - er0, 256);
      check("sat_err_count", err_count, 8'hFF);
      er0 = n_err;
      frame(32'h0, 0);
      check("sat_extra_pulse", n_err - er0, 1);
      check("sat_hold", err_count, 8'hFF);

      check("no_overlap", n_both, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
